adc_sample_conditioner: RTL and testbench
=========================================

# adc_sample_conditioner

Upstream conditioning stage for the 8-bit parallel ADC bus on the JA header. It synchronises the raw ADC pins into the processor clock domain and decimates them with a fixed sample-period divider. It boxcar-averages 2^AVG_LOG2 decimated samples and publishes each result with a sticky ready/overrun handshake. Its outputs feed the ADC data register (r1) and ADC-ready register (r8) of the register file, replacing the raw pin path and free-running ready counter.

## Interface
Parameters:
- DIVIDE, 500: clock cycles between decimated samples (≥2).
- AVG_LOG2, 2: log2 of the number of samples averaged per published result (0..4).

Ports:
- clock  in  1  processor clock; the block uses one clock.
- ctrl_reset  in  1  reset; synchronous, active-high.
- adc_raw  in  8  raw ADC bus (JA), asynchronous to clock.
- ready_clear  in  1  one-cycle acknowledge from the processor side; clears adc_ready and adc_overrun.
- adc_sample  out  8  most recent averaged sample.
- adc_ready  out  1  sticky; high when adc_sample holds a result not yet acknowledged.
- adc_overrun  out  1  sticky; high when a result was published while adc_ready was still set.
- sample_tick  out  1  one-cycle pulse on every decimation tick (debug/LED use).

## Operation
- Synchroniser: two flops per bit, sync1 <= adc_raw and sync2 <= sync1, every cycle. Only sync2 is used downstream.
- Divider: div_cnt counts 0..DIVIDE-1 and wraps to 0.
  - A tick is a cycle with div_cnt == DIVIDE-1.
  - sample_tick is registered and is high in the cycle after the tick edge.
- Accumulator: acc is 8+AVG_LOG2 bits wide; idx counts 0..2^AVG_LOG2-1.
  - On a tick with idx < N-1: acc <= acc + sync2 and idx <= idx+1.
  - On a tick with idx == N-1 (publish): adc_sample <= (acc + sync2) >> AVG_LOG2 (floor, no rounding), acc <= 0, idx <= 0.
  - The accumulator never overflows at the declared width.
- Handshake, evaluated each edge in priority order:
  - Publish with ready_clear: adc_ready <= 1, adc_overrun <= 0.
  - Publish with adc_ready == 1 and no ready_clear: adc_sample updates (newest wins), adc_ready stays 1, adc_overrun <= 1.
  - Publish with adc_ready == 0: adc_ready <= 1, adc_overrun unchanged.
  - ready_clear without publish: adc_ready <= 0, adc_overrun <= 0.
- AVG_LOG2 == 0: every tick is a publish; adc_sample = sync2.

## Timing
- Reset values, all zero: adc_sample, adc_ready, adc_overrun, sample_tick, sync1, sync2, div_cnt, acc, idx.
- ctrl_reset is sampled at each clock edge and overrides all other inputs. Reset mid-window discards the partial accumulation and restarts the divider from 0.
- Pin to sync2: 2 clock edges.
- Counting edge 1 as the first edge with ctrl_reset low:
  - Ticks occur at edges k·DIVIDE.
  - The first publish is at edge N·DIVIDE, with N = 2^AVG_LOG2.
  - adc_ready rises in the cycle after that edge.
  - Publishes then repeat every N·DIVIDE edges.
- Each tick samples the sync2 value present during the tick cycle. An input change must therefore occur at least 2 cycles before a tick to be included in it.
- ready_clear is level-sampled each edge. Holding it high for multiple cycles is legal; a result published while it is held is acknowledged immediately (adc_ready still pulses high for one cycle).
- All outputs are registered. There are no combinational paths from input to output.

## Test plan
All scenarios use DIVIDE=4 and AVG_LOG2=2.
- Reset/constant input: hold adc_raw=0x80 from reset. Required: outputs are 0 through edge 15; sample_tick pulses after edges 4, 8, 12, 16; after edge 16, adc_sample=0x80 and adc_ready=1.
- Averaging/truncation: set adc_raw to 10, 20, 30, 41, each stable ≥3 cycles before its tick. Required: adc_sample=25 (floor(101/4)). Repeat with all 0xFF; required: adc_sample=0xFF with no overflow.
- Handshake: after a publish, pulse ready_clear. Required: adc_ready=0 next cycle, adc_sample held; adc_ready returns to 1 after the next publish 16 cycles later.
- Overrun: never assert ready_clear across two publishes, input 0x10 then 0x20. Required: adc_sample=0x20, adc_ready=1, adc_overrun=1; a single ready_clear then clears both flags.
- Simultaneous events: assert ready_clear on the publish edge while adc_ready=1. Required: adc_ready=1, adc_overrun=0, adc_sample updated.
- Reset mid-window: assert ctrl_reset for one cycle after 2 ticks. Required: all outputs 0; the next publish occurs exactly 16 edges after reset release and averages only post-reset samples.

Source files
------------

// File: rtl/adc_sample_conditioner.sv
// Synchronises the 8-bit ADC bus, decimates it by DIVIDE and boxcar-averages 2^AVG_LOG2
// samples, publishing each result with a sticky ready/overrun handshake.
module adc_sample_conditioner #(
    parameter int unsigned DIVIDE   = 500,
    parameter int unsigned AVG_LOG2 = 2
) (
    input  logic       clock,
    input  logic       ctrl_reset,
    input  logic [7:0] adc_raw,
    input  logic       ready_clear,
    output logic [7:0] adc_sample,
    output logic       adc_ready,
    output logic       adc_overrun,
    output logic       sample_tick
);

    localparam int unsigned N    = 1 << AVG_LOG2;
    localparam int unsigned CntW = (DIVIDE > 2) ? $clog2(DIVIDE) : 1;
    localparam int unsigned AccW = 8 + AVG_LOG2;
    localparam int unsigned IdxW = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;

    logic [7:0]      sync1, sync2;
    logic [CntW-1:0] div_cnt;
    logic [AccW-1:0] acc;
    logic [IdxW-1:0] idx;

    logic            tick;
    logic            publish;
    logic [AccW-1:0] sum;

    assign tick    = (div_cnt == CntW'(DIVIDE - 1));
    assign publish = tick && (idx == IdxW'(N - 1));
    // Width holds N*255, so the running sum cannot wrap.
    assign sum     = acc + AccW'(sync2);

    always_ff @(posedge clock) begin
        if (ctrl_reset) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= adc_raw;
            sync2 <= sync1;
        end
    end

    always_ff @(posedge clock) begin
        if (ctrl_reset) begin
            div_cnt     <= '0;
            sample_tick <= 1'b0;
        end else begin
            div_cnt     <= tick ? '0 : div_cnt + CntW'(1);
            sample_tick <= tick;
        end
    end

    always_ff @(posedge clock) begin
        if (ctrl_reset) begin
            acc <= '0;
            idx <= '0;
        end else if (publish) begin
            acc <= '0;
            idx <= '0;
        end else if (tick) begin
            acc <= sum;
            idx <= idx + IdxW'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (ctrl_reset) begin
            adc_sample  <= '0;
            adc_ready   <= 1'b0;
            adc_overrun <= 1'b0;
        end else if (publish) begin
            adc_sample <= 8'(sum >> AVG_LOG2);
            if (ready_clear) begin
                // Acknowledge lands on the publish edge: the new result is still flagged.
                adc_ready   <= 1'b1;
                adc_overrun <= 1'b0;
            end else if (adc_ready) begin
                adc_overrun <= 1'b1;
            end else begin
                adc_ready <= 1'b1;
            end
        end else if (ready_clear) begin
            adc_ready   <= 1'b0;
            adc_overrun <= 1'b0;
        end
    end

endmodule

// File: tb/tb_adc_sample_conditioner.sv
// Scoreboard bench for adc_sample_conditioner with DIVIDE=4, AVG_LOG2=2: stimulus queues the
// expected result of each averaging window, a negedge monitor checks it at every fourth tick.
module tb_adc_sample_conditioner;

    typedef struct packed {
        logic [7:0] sample;
        logic       ready;
        logic       overrun;
    } exp_t;

    logic       clock = 1'b0;
    logic       ctrl_reset;
    logic [7:0] adc_raw;
    logic       ready_clear;
    logic [7:0] adc_sample;
    logic       adc_ready;
    logic       adc_overrun;
    logic       sample_tick;

    int   tests = 0;
    int   fails = 0;
    int   ticks_seen = 0;
    exp_t sb[$];
    logic [7:0] last_sample = 8'h00;

    adc_sample_conditioner #(
        .DIVIDE  (4),
        .AVG_LOG2(2)
    ) dut (
        .clock      (clock),
        .ctrl_reset (ctrl_reset),
        .adc_raw    (adc_raw),
        .ready_clear(ready_clear),
        .adc_sample (adc_sample),
        .adc_ready  (adc_ready),
        .adc_overrun(adc_overrun),
        .sample_tick(sample_tick)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Publish monitor: every fourth sample_tick since reset carries a new result.
    always @(negedge clock) begin
        exp_t e;
        if (ctrl_reset === 1'b1) begin
            ticks_seen = 0;
        end else if (sample_tick === 1'b1) begin
            ticks_seen++;
            if (ticks_seen % 4 == 0) begin
                if (sb.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL pub_unexpected: got sample 0x%0h, expected no publish",
                             adc_sample);
                end else begin
                    e = sb.pop_front();
                    check("pub_sample", adc_sample, e.sample);
                    check("pub_ready", adc_ready, e.ready);
                    check("pub_overrun", adc_overrun, e.overrun);
                end
            end
        end
    end

    // One 16-edge averaging window starting just after a window boundary.
    task automatic window(input logic [7:0] a, b, c, d,
                          input bit clr_first, input bit clr_pub, input bit idle,
                          input logic [7:0] es, input logic eo);
        logic [7:0] v[4];
        v[0] = a; v[1] = b; v[2] = c; v[3] = d;
        sb.push_back('{sample: es, ready: 1'b1, overrun: eo});
        for (int e = 1; e <= 16; e++) begin
            if ((e - 1) % 4 == 0) adc_raw = v[(e-1)/4];
            ready_clear = (clr_first && e == 1) || (clr_pub && e == 16);
            @(posedge clock);
            #1;
            if (clr_first && e == 1) begin
                check("clr_ready", adc_ready, 0);
                check("clr_overrun", adc_overrun, 0);
                check("clr_sample_held", adc_sample, last_sample);
            end
            if (idle && e == 15) begin
                check("pre_pub_ready", adc_ready, 0);
                check("pre_pub_sample", adc_sample, last_sample);
            end
        end
        ready_clear = 1'b0;
        check("post_pub_ready", adc_ready, 1);
        last_sample = es;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        ctrl_reset  = 1'b1;
        adc_raw     = 8'h80;
        ready_clear = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        check("rst_sample", adc_sample, 0);
        check("rst_ready", adc_ready, 0);
        check("rst_overrun", adc_overrun, 0);
        check("rst_tick", sample_tick, 0);
        ctrl_reset = 1'b0;

        // Constant 0x80 from reset: quiet through edge 15, first publish at edge 16.
        sb.push_back('{sample: 8'h80, ready: 1'b1, overrun: 1'b0});
        for (int e = 1; e <= 16; e++) begin
            @(posedge clock);
            #1;
            check("tick_pattern", sample_tick, (e % 4 == 0) ? 1 : 0);
            if (e < 16) begin
                check("early_ready", adc_ready, 0);
                check("early_sample", adc_sample, 0);
            end else begin
                check("first_ready", adc_ready, 1);
            end
        end
        last_sample = 8'h80;

        // Floor(101/4) = 25, then full-scale without wrap.
        window(8'd10, 8'd20, 8'd30, 8'd41, 1'b1, 1'b0, 1'b1, 8'd25, 1'b0);
        window(8'hFF, 8'hFF, 8'hFF, 8'hFF, 1'b1, 1'b0, 1'b1, 8'hFF, 1'b0);

        // Overrun, newest wins, single clear drops both flags.
        window(8'h10, 8'h10, 8'h10, 8'h10, 1'b1, 1'b0, 1'b1, 8'h10, 1'b0);
        window(8'h20, 8'h20, 8'h20, 8'h20, 1'b0, 1'b0, 1'b0, 8'h20, 1'b1);
        window(8'h30, 8'h30, 8'h30, 8'h30, 1'b1, 1'b0, 1'b1, 8'h30, 1'b0);

        // Clear on the publish edge while ready and overrun are set.
        window(8'h50, 8'h50, 8'h50, 8'h50, 1'b0, 1'b0, 1'b0, 8'h50, 1'b1);
        window(8'h60, 8'h60, 8'h60, 8'h60, 1'b0, 1'b1, 1'b0, 8'h60, 1'b0);

        // Reset after two ticks of a window: partial 0x70 sum is discarded.
        adc_raw = 8'h70;
        repeat (10) @(posedge clock);
        #1;
        ctrl_reset = 1'b1;
        @(posedge clock);
        #1;
        ctrl_reset = 1'b0;
        check("mid_rst_sample", adc_sample, 0);
        check("mid_rst_ready", adc_ready, 0);
        check("mid_rst_overrun", adc_overrun, 0);
        check("mid_rst_tick", sample_tick, 0);
        last_sample = 8'h00;
        window(8'd1, 8'd2, 8'd3, 8'd3, 1'b0, 1'b0, 1'b1, 8'd2, 1'b0);

        repeat (2) @(posedge clock);
        #1;
        check("sb_drained", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
